dcache_wb_buffer: RTL and testbench

DCACHE_WB_BUFFER -- requirements
Module: dcache_wb_buffer

---
 rtl/dcache_wb_buffer.sv | 151 +++++++++++++++
 tb/tb_dcache_wb_buffer.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dcache_wb_buffer.sv
// Write-back buffer between the D$ and the AXI bridge: queues dirty victim lines, drains them
// one at a time, and answers miss-address lookups. Optional coalescing: DCACHE_WB_COALESCE_EN.
module dcache_wb_buffer #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned LINE_BYTES = 64,
    parameter int unsigned DEPTH      = 4
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    wb_req_valid_i,
    output logic                    wb_req_ready_o,
    input  logic [ADDR_WIDTH-1:0]   wb_req_addr_i,
    input  logic [LINE_BYTES*8-1:0] wb_req_data_i,
    output logic                    bridge_req_valid_o,
    input  logic                    bridge_req_ready_i,
    output logic [ADDR_WIDTH-1:0]   bridge_req_addr_o,
    output logic [LINE_BYTES*8-1:0] bridge_req_data_o,
    input  logic                    bridge_resp_valid_i,
    output logic                    bridge_resp_ready_o,
    input  logic [ADDR_WIDTH-1:0]   lookup_addr_i,
    output logic                    lookup_hit_o,
    output logic [LINE_BYTES*8-1:0] lookup_data_o,
    output logic                    empty_o
);
    localparam int unsigned DataW = LINE_BYTES * 8;
    localparam int unsigned PtrW  = $clog2(DEPTH);
    localparam int unsigned CntW  = PtrW + 1;
    localparam logic [ADDR_WIDTH-1:0] LineMask = ~ADDR_WIDTH'(LINE_BYTES - 1);
    localparam logic [CntW-1:0] CntFull = CntW'(DEPTH);

    typedef enum logic [1:0] {StIdle, StSend, StWait} state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q [DEPTH];
    logic [DataW-1:0]      data_q [DEPTH];
    logic [DEPTH-1:0]      valid_q, valid_d;
    logic [PtrW-1:0]       head_q, head_d, tail_q, tail_d;
    logic [CntW-1:0]       count_q, count_d;
    logic [PtrW-1:0]       age_idx [DEPTH];
    logic [ADDR_WIDTH-1:0] push_line, lookup_line;
    logic                  push, alloc, pop, coal_hit;
    logic [PtrW-1:0]       coal_idx, wr_idx;

    assign push_line   = wb_req_addr_i & LineMask;
    assign lookup_line = lookup_addr_i & LineMask;

    // Entries listed oldest first, so a later match in a scan is always the younger one.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            age_idx[i] = head_q + PtrW'(i);
        end
    end

    assign wb_req_ready_o = (count_q < CntFull);
    assign push           = wb_req_valid_i && wb_req_ready_o;

`ifdef DCACHE_WB_COALESCE_EN
    // The head is excluded once it has been offered to the bridge so its data stays stable.
    always_comb begin
        coal_hit = 1'b0;
        coal_idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid_q[age_idx[i]] && (addr_q[age_idx[i]] == push_line) &&
                ((i != 0) || (state_q == StIdle))) begin
                coal_hit = 1'b1;
                coal_idx = age_idx[i];
            end
        end
    end
`else
    assign coal_hit = 1'b0;
    assign coal_idx = '0;
`endif

    assign alloc  = push && !coal_hit;
    assign wr_idx = coal_hit ? coal_idx : tail_q;

    always_comb begin
        state_d             = state_q;
        bridge_req_valid_o  = 1'b0;
        bridge_resp_ready_o = 1'b0;
        pop                 = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (count_q != '0) state_d = StSend;
            end
            StSend: begin
                bridge_req_valid_o = 1'b1;
                if (bridge_req_ready_i) state_d = StWait;
            end
            StWait: begin
                bridge_resp_ready_o = 1'b1;
                if (bridge_resp_valid_i) begin
                    pop     = 1'b1;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign bridge_req_addr_o = bridge_req_valid_o ? addr_q[head_q] : '0;
    assign bridge_req_data_o = bridge_req_valid_o ? data_q[head_q] : '0;

    always_comb begin
        valid_d = valid_q;
        if (pop)   valid_d[head_q] = 1'b0;
        if (alloc) valid_d[tail_q] = 1'b1;
        head_d  = pop   ? head_q + PtrW'(1) : head_q;
        tail_d  = alloc ? tail_q + PtrW'(1) : tail_q;
        count_d = count_q + CntW'(alloc) - CntW'(pop);
    end

    always_comb begin
        lookup_hit_o  = 1'b0;
        lookup_data_o = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid_q[age_idx[i]] && (addr_q[age_idx[i]] == lookup_line)) begin
                lookup_hit_o  = 1'b1;
                lookup_data_o = data_q[age_idx[i]];
            end
        end
    end

    assign empty_o = (count_q == '0) && (state_q == StIdle);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            valid_q <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Payload storage needs no reset: every read is qualified by a valid bit or the SEND state.
    always_ff @(posedge clk_i) begin
        if (push) begin
            addr_q[wr_idx] <= push_line;
            data_q[wr_idx] <= wb_req_data_i;
        end
    end

endmodule

// File: tb/tb_dcache_wb_buffer.sv
// Self-checking bench for dcache_wb_buffer: directed scenarios plus randomized traffic,
// compared each cycle against a queue-based model of the buffer contents.
module tb_dcache_wb_buffer;
    localparam int AW    = 32;
    localparam int LB    = 64;
    localparam int DW    = LB * 8;
    localparam int DEPTH = 4;

    logic          clk_i = 1'b0;
    logic          rst_ni;
    logic          wb_req_valid_i, wb_req_ready_o;
    logic [AW-1:0] wb_req_addr_i;
    logic [DW-1:0] wb_req_data_i;
    logic          bridge_req_valid_o, bridge_req_ready_i;
    logic [AW-1:0] bridge_req_addr_o;
    logic [DW-1:0] bridge_req_data_o;
    logic          bridge_resp_valid_i, bridge_resp_ready_o;
    logic [AW-1:0] lookup_addr_i;
    logic          lookup_hit_o;
    logic [DW-1:0] lookup_data_o;
    logic          empty_o;

    always #5 clk_i = ~clk_i;

    dcache_wb_buffer #(.ADDR_WIDTH(AW), .LINE_BYTES(LB), .DEPTH(DEPTH)) dut (
        .clk_i              (clk_i),
        .rst_ni             (rst_ni),
        .wb_req_valid_i     (wb_req_valid_i),
        .wb_req_ready_o     (wb_req_ready_o),
        .wb_req_addr_i      (wb_req_addr_i),
        .wb_req_data_i      (wb_req_data_i),
        .bridge_req_valid_o (bridge_req_valid_o),
        .bridge_req_ready_i (bridge_req_ready_i),
        .bridge_req_addr_o  (bridge_req_addr_o),
        .bridge_req_data_o  (bridge_req_data_o),
        .bridge_resp_valid_i(bridge_resp_valid_i),
        .bridge_resp_ready_o(bridge_resp_ready_o),
        .lookup_addr_i      (lookup_addr_i),
        .lookup_hit_o       (lookup_hit_o),
        .lookup_data_o      (lookup_data_o),
        .empty_o            (empty_o)
    );

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } line_t;

    // Model: queued lines oldest first; xfer_stage 0 = head not yet offered,
    // 1 = head offered to the bridge, 2 = head accepted and awaiting completion.
    line_t mq[$];
    int    xfer_stage;
    int    vectors;
    int    miscompares;

    function automatic logic [AW-1:0] line_of(input logic [AW-1:0] a);
        logic [AW-1:0] m;
        m = AW'(LB - 1);
        return a & ~m;
    endfunction

    function automatic logic [DW-1:0] rand_data();
        logic [DW-1:0] d;
        for (int i = 0; i < DW / 32; i++) d[i*32 +: 32] = $urandom;
        return d;
    endfunction

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        logic          hit;
        logic [DW-1:0] ld;
        hit = 1'b0;
        ld  = '0;
        foreach (mq[i]) begin
            if (mq[i].addr == line_of(lookup_addr_i)) begin
                hit = 1'b1;
                ld  = mq[i].data;
            end
        end
        chk("wb_req_ready", DW'(wb_req_ready_o), DW'(mq.size() < DEPTH));
        chk("bridge_req_valid", DW'(bridge_req_valid_o), DW'(xfer_stage == 1));
        chk("bridge_resp_ready", DW'(bridge_resp_ready_o), DW'(xfer_stage == 2));
        chk("empty", DW'(empty_o), DW'(mq.size() == 0));
        chk("lookup_hit", DW'(lookup_hit_o), DW'(hit));
        chk("lookup_data", lookup_data_o, ld);
        if (xfer_stage == 1) begin
            chk("bridge_req_addr", DW'(bridge_req_addr_o), DW'(mq[0].addr));
            chk("bridge_req_data", bridge_req_data_o, mq[0].data);
        end
    endtask

    // Called shortly after a rising edge with inputs applied; checks, advances the model, clocks.
    task automatic tick();
        bit    do_push, do_send, do_done;
        int    nstage, k;
        line_t e;
        #1;
        check_outputs();
        do_push = wb_req_valid_i && (mq.size() < DEPTH);
        do_send = (xfer_stage == 1) && bridge_req_ready_i;
        do_done = (xfer_stage == 2) && bridge_resp_valid_i;
        nstage  = xfer_stage;
        if (xfer_stage == 0 && mq.size() > 0) nstage = 1;
        else if (do_send) nstage = 2;
        else if (do_done) nstage = 0;
        k = -1;
`ifdef DCACHE_WB_COALESCE_EN
        if (do_push) begin
            foreach (mq[i]) begin
                if (mq[i].addr == line_of(wb_req_addr_i) && (i != 0 || xfer_stage == 0)) k = i;
            end
        end
`endif
        if (do_push && k >= 0) mq[k].data = wb_req_data_i;
        if (do_done) void'(mq.pop_front());
        if (do_push && k < 0) begin
            e.addr = line_of(wb_req_addr_i);
            e.data = wb_req_data_i;
            mq.push_back(e);
        end
        xfer_stage = nstage;
        @(posedge clk_i);
        #1;
    endtask

    task automatic push_line(input logic [AW-1:0] a, input logic [DW-1:0] d);
        wb_req_valid_i = 1'b1;
        wb_req_addr_i  = a;
        wb_req_data_i  = d;
        tick();
        wb_req_valid_i = 1'b0;
    endtask

    task automatic drain(input string tag);
        wb_req_valid_i      = 1'b0;
        bridge_req_ready_i  = 1'b1;
        bridge_resp_valid_i = 1'b1;
        for (int c = 0; c < 100 && (mq.size() > 0 || xfer_stage != 0); c++) tick();
        #1;
        chk(tag, DW'(empty_o), DW'(1));
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_wb_ready"}, DW'(wb_req_ready_o), DW'(1));
        chk({tag, "_req_valid"}, DW'(bridge_req_valid_o), DW'(0));
        chk({tag, "_resp_ready"}, DW'(bridge_resp_ready_o), DW'(0));
        chk({tag, "_req_addr"}, DW'(bridge_req_addr_o), DW'(0));
        chk({tag, "_req_data"}, bridge_req_data_o, DW'(0));
        chk({tag, "_hit"}, DW'(lookup_hit_o), DW'(0));
        chk({tag, "_lookup_data"}, lookup_data_o, DW'(0));
        chk({tag, "_empty"}, DW'(empty_o), DW'(1));
    endtask

    initial begin
        int            pushed;
        logic [DW-1:0] pat_a, pat_b, pat_l;
        vectors             = 0;
        miscompares         = 0;
        xfer_stage          = 0;
        rst_ni              = 1'b0;
        wb_req_valid_i      = 1'b0;
        wb_req_addr_i       = '0;
        wb_req_data_i       = '0;
        bridge_req_ready_i  = 1'b0;
        bridge_resp_valid_i = 1'b0;
        lookup_addr_i       = '0;
        pat_a = {16{32'hA5A5_0001}};
        pat_b = {16{32'hB00B_0002}};
        pat_l = {16{32'h3C3C_0003}};

        #12;
        check_reset_values("reset");
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(posedge clk_i);
        #1;

        // Single line through an empty buffer.
        lookup_addr_i = 32'h0000_1040;
        push_line(32'h0000_1040, pat_a);
        drain("single_empty");

        // Fill with the bridge stalled; a fifth push must be refused.
        bridge_req_ready_i  = 1'b0;
        bridge_resp_valid_i = 1'b0;
        for (int i = 0; i < DEPTH; i++) push_line(32'h0001_0000 + i * 64, rand_data());
        chk("full_not_ready", DW'(wb_req_ready_o), DW'(0));
        push_line(32'h0001_0800, rand_data());
        bridge_req_ready_i  = 1'b1;
        bridge_resp_valid_i = 1'b1;
        for (int c = 0; c < 20 && mq.size() == DEPTH; c++) tick();
        #1;
        chk("full_ready_back", DW'(wb_req_ready_o), DW'(1));
        drain("full_drained");

        // Ten pushes with random stalls so the pointers wrap.
        pushed = 0;
        for (int c = 0; c < 600 && (pushed < 10 || mq.size() > 0 || xfer_stage != 0); c++) begin
            wb_req_valid_i      = (pushed < 10) && ($urandom_range(0, 1) == 1);
            wb_req_addr_i       = 32'h0002_0000 + pushed * 64 + $urandom_range(0, 63);
            wb_req_data_i       = rand_data();
            bridge_req_ready_i  = $urandom_range(0, 1) == 1;
            bridge_resp_valid_i = $urandom_range(0, 1) == 1;
            lookup_addr_i       = 32'h0002_0000 + $urandom_range(0, 11) * 64;
            if (wb_req_valid_i && mq.size() < DEPTH) pushed++;
            tick();
        end
        drain("wrap_drained");

        // Head in flight, then two pushes to the same line.
        bridge_req_ready_i  = 1'b0;
        bridge_resp_valid_i = 1'b0;
        push_line(32'h0000_1000, rand_data());
        tick();
        push_line(32'h0000_2000, rand_data());
        push_line(32'h0000_2000, pat_b);
        lookup_addr_i = 32'h0000_2010;
        push_line(32'h0000_5000, rand_data());
        #1;
`ifdef DCACHE_WB_COALESCE_EN
        chk("coalesce_ready", DW'(wb_req_ready_o), DW'(1));
`else
        chk("no_coalesce_full", DW'(wb_req_ready_o), DW'(0));
`endif
        chk("coalesce_lookup", lookup_data_o, pat_b);
        drain("coalesce_drained");

        // Lookup inside and just past a buffered line.
        bridge_req_ready_i = 1'b0;
        push_line(32'h0000_3000, pat_l);
        lookup_addr_i = 32'h0000_3024;
        #1;
        chk("lookup_3024_hit", DW'(lookup_hit_o), DW'(1));
        chk("lookup_3024_data", lookup_data_o, pat_l);
        tick();
        lookup_addr_i = 32'h0000_3040;
        #1;
        chk("lookup_3040_hit", DW'(lookup_hit_o), DW'(0));
        chk("lookup_3040_data", lookup_data_o, DW'(0));
        tick();
        drain("lookup_drained");

        // Reset while the head waits for its completion.
        bridge_req_ready_i  = 1'b1;
        bridge_resp_valid_i = 1'b0;
        for (int i = 0; i < 3; i++) push_line(32'h0004_0000 + i * 64, rand_data());
        for (int c = 0; c < 10 && xfer_stage != 2; c++) tick();
        lookup_addr_i = 32'h0004_0040;
        #1;
        chk("pre_reset_resp_ready", DW'(bridge_resp_ready_o), DW'(1));
        #1;
        rst_ni = 1'b0;
        #1;
        check_reset_values("mid_wait_reset");
        mq.delete();
        xfer_stage = 0;
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(posedge clk_i);
        #1;
        bridge_resp_valid_i = 1'b1;
        for (int c = 0; c < 6; c++) tick();

        // Random traffic over a small address pool for duplicate lines and lookup hits.
        for (int c = 0; c < 150; c++) begin
            wb_req_valid_i      = $urandom_range(0, 2) != 0;
            wb_req_addr_i       = 32'h0006_0000 + $urandom_range(0, 5) * 64 + $urandom_range(0, 63);
            wb_req_data_i       = rand_data();
            bridge_req_ready_i  = $urandom_range(0, 2) == 0;
            bridge_resp_valid_i = $urandom_range(0, 2) == 0;
            lookup_addr_i       = 32'h0006_0000 + $urandom_range(0, 6) * 64 + $urandom_range(0, 63);
            tick();
        end
        drain("random_drained");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
